// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
//  Shared definitions for the 8x8 signed MAC datapath and its sequencer:
//  operand/psum widths and the sequencer state encoding.
//  No ports (package).
// ----------------------------------------------------------------------------
package mac_pkg;

   localparam int MAC_A_W = 8;
   localparam int MAC_B_W = 8;
   localparam int MAC_P_W = 20;

   // Sequencer state encoding, kept as plain constants so older tools and
   // waveform viewers that expect fixed codes stay compatible.
   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
   localparam logic [ST_W-1:0] ST_FEED  = 3'd2;
   localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
   localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage : mac_pkg

// File: rtl/mac.sv
// ----------------------------------------------------------------------------
// mac
//  8x8 signed multiply-accumulate with a 20-bit partial sum, DSP style:
//  product register followed by accumulator register, so an operand pair on
//  i_a/i_b is reflected in o_mac two cycles later.
// Ports
//  clk, rst_n   clock, asynchronous active-low reset
//  i_a, i_b     signed operands
//  sclr         synchronous clear of product and accumulator
//  o_mac        signed accumulated sum
// ----------------------------------------------------------------------------
module mac
   import mac_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [MAC_A_W-1:0] i_a,
   input  logic signed [MAC_B_W-1:0] i_b,
   input  logic                      sclr,
   output logic signed [MAC_P_W-1:0] o_mac
);

   logic signed [MAC_A_W+MAC_B_W-1:0] r_prod;

   // NOTE: sequential state is always assigned with <= so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         o_mac  <= '0;
      end else if (sclr) begin
         r_prod <= '0;
         o_mac  <= '0;
      end else begin
         r_prod <= i_a * i_b;
         o_mac  <= o_mac + MAC_P_W'(r_prod);
      end
   end

endmodule : mac

// File: rtl/mac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mac_seq_ctrl
//  Sequencer for one mac instance. Accepts a dot-product command of length N,
//  clears the MAC, streams N operand pairs into it, waits for the MAC pipeline
//  to drain and presents the 20-bit sum until the consumer takes it.
// Ports
//  clk, rst_n            clock, asynchronous active-low reset
//  cmd_valid/cmd_ready   command handshake (ready only when idle)
//  cmd_len               number of operand pairs N (0 allowed)
//  op_valid/op_ready     operand handshake (ready only while feeding)
//  op_a, op_b            signed operand pair
//  res_valid/res_ready   result handshake; res_data held while valid
//  res_data              signed dot-product result
//  busy                  high whenever not idle
//  mac_a, mac_b          registered operands to the mac
//  mac_sclr              registered synchronous clear to the mac
//  mac_o                 accumulated sum from the mac
// ----------------------------------------------------------------------------
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int LEN_W   = 5,
   parameter int MAC_LAT = 2,
   parameter int CLR_CYC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [MAC_A_W-1:0] op_a,
   input  logic [MAC_B_W-1:0] op_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [MAC_P_W-1:0] res_data,
   output logic               busy,
   output logic [MAC_A_W-1:0] mac_a,
   output logic [MAC_B_W-1:0] mac_b,
   output logic               mac_sclr,
   input  logic [MAC_P_W-1:0] mac_o
);

   // One down-counter times both CLEAR and DRAIN, so it is sized for the
   // longer of the two waits.
   localparam int TMR_MAX = (CLR_CYC > MAC_LAT) ? CLR_CYC : MAC_LAT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYC - 1);
   // DRAIN lasts MAC_LAT+1 cycles: one for the operand register in this
   // block, MAC_LAT for the mac pipeline. Counting from MAC_LAT down to zero
   // gives exactly that many cycles.
   localparam logic [TMR_W-1:0] DRN_LOAD = TMR_W'(MAC_LAT);

   logic [ST_W-1:0]  r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_count;
   logic [TMR_W-1:0] r_tmr;

   logic w_cmd_hs;
   logic w_op_hs;
   logic w_last_op;

   assign cmd_ready = (r_state == ST_IDLE);
   assign op_ready  = (r_state == ST_FEED);
   assign busy      = (r_state != ST_IDLE);

   assign w_cmd_hs  = cmd_valid & cmd_ready;
   assign w_op_hs   = op_valid & op_ready;
   // FEED is only entered with r_len >= 1, so r_len-1 never underflows here.
   assign w_last_op = w_op_hs && (r_count == r_len - LEN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_len     <= '0;
         r_count   <= '0;
         r_tmr     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         mac_a     <= '0;
         mac_b     <= '0;
         mac_sclr  <= 1'b1;
      end else begin
         // Zero operands by default: a stall or drain cycle adds nothing.
         mac_a <= '0;
         mac_b <= '0;
         case (r_state)
            ST_IDLE: begin
               mac_sclr <= 1'b1;
               if (w_cmd_hs) begin
                  r_len   <= cmd_len;
                  r_count <= '0;
                  r_tmr   <= CLR_LOAD;
                  r_state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (r_tmr == '0) begin
                  mac_sclr <= 1'b0;
                  if (r_len == '0) begin
                     r_tmr   <= DRN_LOAD;
                     r_state <= ST_DRAIN;
                  end else begin
                     r_state <= ST_FEED;
                  end
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_FEED: begin
               if (w_op_hs) begin
                  mac_a   <= op_a;
                  mac_b   <= op_b;
                  r_count <= r_count + LEN_W'(1);
                  if (w_last_op) begin
                     r_tmr   <= DRN_LOAD;
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_tmr == '0) begin
                  res_data  <= mac_o;
                  res_valid <= 1'b1;
                  r_state   <= ST_DONE;
               end else begin
                  r_tmr <= r_tmr - TMR_W'(1);
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  mac_sclr  <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : mac_seq_ctrl

// File: tb/tb_mac_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_seq_ctrl
//  Directed bench for mac_seq_ctrl driving a real mac instance. Inputs are
//  driven and outputs sampled on the falling clock edge; expected sums are
//  hand-computed constants.
// ----------------------------------------------------------------------------
module tb_mac_seq_ctrl;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_len;
   logic              op_valid;
   logic              op_ready;
   logic [7:0]        op_a;
   logic [7:0]        op_b;
   logic              res_valid;
   logic              res_ready;
   logic signed [19:0] res_data;
   logic              busy;
   logic [7:0]        mac_a;
   logic [7:0]        mac_b;
   logic              mac_sclr;
   logic signed [19:0] mac_o;

   logic signed [7:0] va [32];
   logic signed [7:0] vb [32];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mac_seq_ctrl #(.LEN_W(5), .MAC_LAT(2), .CLR_CYC(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_sclr  (mac_sclr),
      .mac_o     (mac_o)
   );

   mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .i_a   (mac_a),
      .i_b   (mac_b),
      .sclr  (mac_sclr),
      .o_mac (mac_o)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      check({tag, "_op_ready"},  int'(op_ready),  0);
      check({tag, "_res_valid"}, int'(res_valid), 0);
      check({tag, "_res_data"},  int'(res_data),  0);
      check({tag, "_busy"},      int'(busy),      0);
      check({tag, "_mac_a"},     int'(mac_a),     0);
      check({tag, "_mac_b"},     int'(mac_b),     0);
      check({tag, "_mac_sclr"},  int'(mac_sclr),  1);
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0;
      cmd_len   = '0;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      res_ready = 1'b0;
   endtask

   // Runs one command from the falling edge with the DUT idle.
   //  tog      : op_valid pattern 1-0-0-1-0-0... instead of always 1
   //  stall    : cycles res_ready is held low once res_valid rises
   //  abort_at : pulse rst_n low once this many pairs were accepted (-1: never)
   task automatic run_txn(input string tag, input int len, input bit tog,
                          input int stall, input int abort_at,
                          output int res, output int n_rdy, output int n_sclr);
      int  i        = 0;
      int  held     = 0;
      bit  cmd_acc  = 1'b0;
      bit  acc_now;
      bit  hs;
      bit  done     = 1'b0;
      bit  aborted  = 1'b0;
      int  first_data = 0;
      res    = 0;
      n_rdy  = 0;
      n_sclr = 0;
      cmd_len = 5'(len);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (abort_at >= 0 && i == abort_at) begin
            rst_n = 1'b0;
            idle_inputs();
            #1;
            check_reset_vals({tag, "_abort"});
            aborted = 1'b1;
            done    = 1'b1;
            break;
         end
         cmd_valid = !cmd_acc;
         op_valid  = (i < len) && (!tog || (cyc % 3 == 0));
         op_a      = (i < len) ? va[i] : 8'sd0;
         op_b      = (i < len) ? vb[i] : 8'sd0;
         res_ready = 1'b0;
         if (busy && mac_sclr) n_sclr++;
         if (op_ready) begin
            n_rdy++;
            check({tag, "_op_ready_busy"}, int'(busy), 1);
         end
         acc_now = cmd_valid && cmd_ready;
         hs      = op_valid && op_ready;
         if (res_valid) begin
            if (held < stall) begin
               if (held == 0) first_data = int'(res_data);
               else           check({tag, "_hold_data"}, int'(res_data), first_data);
               check({tag, "_hold_cmd_ready"}, int'(cmd_ready), 0);
               // A competing command during DONE must be ignored.
               cmd_valid = 1'b1;
               cmd_len   = 5'd3;
               held++;
            end else begin
               res_ready = 1'b1;
               res       = int'(res_data);
               done      = 1'b1;
            end
         end
         @(posedge clk);
         if (acc_now) cmd_acc = 1'b1;
         if (hs) i++;
         @(negedge clk);
         if (done) break;
      end
      idle_inputs();
      if (!done) check({tag, "_timeout"}, 0, 1);
      else if (!aborted) begin
         check({tag, "_post_res_valid"}, int'(res_valid), 0);
         check({tag, "_post_cmd_ready"}, int'(cmd_ready), 1);
         check({tag, "_post_mac_sclr"},  int'(mac_sclr),  1);
      end
   endtask

   initial begin
      int res, n_rdy, n_sclr;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_rel");

      // 1: (1,2)(3,4)(-5,6)(7,-8) -> 2 + 12 - 30 - 56 = -72
      va[0] = 1;  vb[0] = 2;
      va[1] = 3;  vb[1] = 4;
      va[2] = -5; vb[2] = 6;
      va[3] = 7;  vb[3] = -8;
      run_txn("t1", 4, 1'b0, 0, -1, res, n_rdy, n_sclr);
      check("t1_res", res, -72);
      check("t1_rdy_cycles", n_rdy, 4);
      check("t1_sclr_cycles", n_sclr, 2);

      // 2: same data with stalls; 4 handshakes spaced 3 apart need >= 10 ready cycles
      run_txn("t2", 4, 1'b1, 0, -1, res, n_rdy, n_sclr);
      check("t2_res", res, -72);
      check("t2_rdy_ge10", int'(n_rdy >= 10), 1);
      check("t2_sclr_cycles", n_sclr, 2);

      // 3: empty command
      run_txn("t3", 0, 1'b0, 0, -1, res, n_rdy, n_sclr);
      check("t3_res", res, 0);
      check("t3_rdy_cycles", n_rdy, 0);
      check("t3_sclr_cycles", n_sclr, 2);

      // 4: 31 * (-128 * -128) = 31 * 16384 = 507904
      for (int k = 0; k < 31; k++) begin
         va[k] = -128;
         vb[k] = -128;
      end
      run_txn("t4", 31, 1'b0, 0, -1, res, n_rdy, n_sclr);
      check("t4_res", res, 507904);
      check("t4_rdy_cycles", n_rdy, 31);

      // 5: result held 10 cycles, then back-to-back second command
      va[0] = 1;  vb[0] = 2;
      va[1] = 3;  vb[1] = 4;
      va[2] = -5; vb[2] = 6;
      va[3] = 7;  vb[3] = -8;
      run_txn("t5a", 4, 1'b0, 10, -1, res, n_rdy, n_sclr);
      check("t5a_res", res, -72);
      // (2,5)(-3,4)(10,10) -> 10 - 12 + 100 = 98
      va[0] = 2;  vb[0] = 5;
      va[1] = -3; vb[1] = 4;
      va[2] = 10; vb[2] = 10;
      run_txn("t5b", 3, 1'b0, 0, -1, res, n_rdy, n_sclr);
      check("t5b_res", res, 98);
      check("t5b_sclr_cycles", n_sclr, 2);

      // 6: reset after 2 of 5 pairs, then (3,3)(2,2) -> 9 + 4 = 13
      for (int k = 0; k < 5; k++) begin
         va[k] = 8'sd50;
         vb[k] = 8'sd50;
      end
      run_txn("t6a", 5, 1'b0, 0, 2, res, n_rdy, n_sclr);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("t6_rel");
      va[0] = 3; vb[0] = 3;
      va[1] = 2; vb[1] = 2;
      run_txn("t6b", 2, 1'b0, 0, -1, res, n_rdy, n_sclr);
      check("t6b_res", res, 13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_mac_seq_ctrl
